// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and priority helper for the
// interrupt pending controller slice.
package irq_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // Index of the highest set bit; 0 when no bit is set.
  function automatic logic [IDX_W-1:0] prio(input logic [N_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc8.sv
// Combinational 8-to-3 priority encoder, bit 7 highest, with an any-bit flag.
module prio_enc8
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Highest set bit wins; any flags a non-empty input.
  always_comb begin
    idx = prio(vec);
    any = |vec;
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: rising-edge capture of request lines into a
// pending register, highest-priority index presented over valid/ready.
// Build option: define IRQ_SYNC_EN to pass each req line through a
// 2-flop synchronizer ahead of the edge detector.
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             irq_ready,
  input  logic             clr_lost,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N_REQ-1:0] pending,
  output logic             lost
);

  logic [N_REQ-1:0] req_s;
  logic [N_REQ-1:0] req_q, req_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic             lost_q, lost_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  state_e           state_q, state_d;

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr_mask;
  logic             accept;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

`ifdef IRQ_SYNC_EN
  logic [N_REQ-1:0] sync1_q, sync2_q;

  // Two-stage synchronizer for asynchronous request lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = req;
`endif

  prio_enc8 u_prio_enc8 (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Edge detect, pending/lost update and presentation FSM next state.
  always_comb begin
    req_d    = req_s;
    rise     = req_s & ~req_q;
    accept   = (state_q == PRESENT) && irq_ready;
    clr_mask = '0;
    if (accept) clr_mask[idx_q] = 1'b1;

    // A rise landing on a bit cleared this cycle re-arms it rather than
    // counting as an overflow.
    pending_d = pending_q & ~clr_mask;
    lost_d    = lost_q & ~clr_lost;
    if (en) begin
      pending_d = pending_d | rise;
      if (|(rise & pending_q & ~clr_mask)) lost_d = 1'b1;
    end

    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (en && enc_any) begin
          idx_d   = enc_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (!en || irq_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      pending_q <= '0;
      lost_q    <= 1'b0;
      idx_q     <= '0;
      state_q   <= IDLE;
    end else begin
      req_q     <= req_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
    end
  end

  assign irq_valid = (state_q == PRESENT);
  assign irq_idx   = idx_q;
  assign pending   = pending_q;
  assign lost      = lost_q;

endmodule
